// File: rtl/glbl_ctrl.sv
// Global control sequencer: drives gsr/gts through a release sequence after
// reset, then asserts ready. Also keeps a free-running cycle counter and a sticky run-limit flag.
module glbl_ctrl #(
  parameter int CNT_W      = 32,
  parameter int GSR_CYCLES = 10,
  parameter int GTS_CYCLES = 4,
  parameter int MAX_CYCLES = 1150
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw_rst_req,
  output logic             gsr,
  output logic             gts,
  output logic             ready,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_GSR = 2'd0,
    ST_GTS = 2'd1,
    ST_RUN = 2'd2
  } state_e;

  // A limit that does not fit in the counter can never be reached.
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_CYCLES);
  localparam bit               MAX_EN = (MAX_CYCLES != 0) &&
                                        ((64'(MAX_CYCLES) >> CNT_W) == 64'd0);
  localparam logic [31:0]      GSR_LAST = 32'(GSR_CYCLES - 1);
  localparam logic [31:0]      GTS_LAST = 32'(GTS_CYCLES - 1);
  localparam bit               HAS_GTS  = (GTS_CYCLES > 0);

  state_e            state_q, state_d;
  logic [31:0]       phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              gsr_q, gsr_d;
  logic              gts_q, gts_d;
  logic              ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_GSR;
      phase_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      gsr_q   <= 1'b1;
      gts_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      gsr_q   <= gsr_d;
      gts_q   <= gts_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 32'd1;
    case (state_q)
      ST_GSR: begin
        if (phase_q == GSR_LAST) begin
          state_d = HAS_GTS ? ST_GTS : ST_RUN;
          phase_d = '0;
        end
      end
      ST_GTS: begin
        if (phase_q == GTS_LAST) begin
          state_d = ST_RUN;
          phase_d = '0;
        end
      end
      ST_RUN: begin
        if (sw_rst_req) begin
          state_d = ST_GSR;
          phase_d = '0;
        end
      end
      default: begin
        state_d = ST_GSR;
        phase_d = '0;
      end
    endcase

    // Strobes are decoded from the next state so they change on the transition edge.
    gsr_d   = (state_d == ST_GSR);
    gts_d   = (state_d != ST_RUN);
    ready_d = (state_d == ST_RUN);

    cnt_d  = cnt_q + CNT_W'(1);
    done_d = done_q | (MAX_EN && (cnt_d == MAX_V));
  end

  assign gsr         = gsr_q;
  assign gts         = gts_q;
  assign ready       = ready_q;
  assign done        = done_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_glbl_ctrl.sv
// Directed bench for glbl_ctrl: default instance plus parameter-corner instances
// (GTS_CYCLES=0, MAX_CYCLES=0, CNT_W=8) sharing clock, reset and request.
module tb_glbl_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw_rst_req = 1'b0;

  logic        d_gsr, d_gts, d_ready, d_done;
  logic [31:0] d_cnt;
  logic        g_gsr, g_gts, g_ready, g_done;
  logic [31:0] g_cnt;
  logic        m_gsr, m_gts, m_ready, m_done;
  logic [31:0] m_cnt;
  logic        w_gsr, w_gts, w_ready, w_done;
  logic [7:0]  w_cnt;

  int n_pass = 0;
  int n_total = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  glbl_ctrl u_dflt (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req),
    .gsr(d_gsr), .gts(d_gts), .ready(d_ready), .done(d_done), .cycle_count(d_cnt)
  );

  glbl_ctrl #(.GTS_CYCLES(0)) u_gts0 (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req),
    .gsr(g_gsr), .gts(g_gts), .ready(g_ready), .done(g_done), .cycle_count(g_cnt)
  );

  glbl_ctrl #(.MAX_CYCLES(0)) u_max0 (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req),
    .gsr(m_gsr), .gts(m_gts), .ready(m_ready), .done(m_done), .cycle_count(m_cnt)
  );

  glbl_ctrl #(.CNT_W(8), .MAX_CYCLES(200)) u_w8 (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req),
    .gsr(w_gsr), .gts(w_gts), .ready(w_ready), .done(w_done), .cycle_count(w_cnt)
  );

  // One edge; the bench tracks the expected default counter itself.
  task automatic tick();
    @(posedge clk);
    exp_cnt = reset ? 0 : exp_cnt + 1;
    #1;
  endtask

  task automatic run_to(input int target);
    sw_rst_req = 1'b0;
    while (exp_cnt < target) tick();
  endtask

  task automatic test_reset();
    $display("test_reset: holding reset 3 cycles");
    reset = 1'b1;
    sw_rst_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({d_cnt, d_gsr, d_gts, d_ready, d_done} !== {32'd0, 4'b1100}) begin
        $display("FAIL reset_dflt: got cnt=%0d gsr=%b gts=%b ready=%b done=%b, want cnt=0 1100",
                 d_cnt, d_gsr, d_gts, d_ready, d_done);
      end else n_pass++;
      n_total++;
      if ({g_gsr, g_gts, g_ready, g_done, m_done, w_done, w_cnt} !== {6'b110000, 8'd0}) begin
        $display("FAIL reset_corners: got g=%b%b%b%b m_done=%b w_done=%b w_cnt=%0d, want 1100 0 0 0",
                 g_gsr, g_gts, g_ready, g_done, m_done, w_done, w_cnt);
      end else n_pass++;
    end
  endtask

  // Release reset and check the release sequence for 20 edges; optionally
  // pulse sw_rst_req while cycle_count equals pulse_at (must be ignored).
  task automatic test_sequence(input int pulse_at);
    $display("test_sequence: release from reset, request pulse at %0d", pulse_at);
    reset = 1'b0;
    sw_rst_req = (pulse_at == 0);
    sw_rst_req = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      sw_rst_req = (k == pulse_at);
      n_total++;
      if ({d_cnt, d_gsr, d_gts, d_ready, d_done} !==
          {32'(k), (k < 10), (k < 14), (k >= 14), 1'b0}) begin
        $display("FAIL seq_k%0d: got cnt=%0d gsr=%b gts=%b ready=%b done=%b, want cnt=%0d %b%b%b0",
                 k, d_cnt, d_gsr, d_gts, d_ready, d_done, k, (k < 10), (k < 14), (k >= 14));
      end else n_pass++;
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_sw_resequence();
    $display("test_sw_resequence: request at cycle_count=100");
    run_to(100);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    n_total++;
    if ({d_cnt, d_gsr, d_gts, d_ready} !== {32'd101, 3'b110}) begin
      $display("FAIL swreq_entry: got cnt=%0d gsr=%b gts=%b ready=%b, want cnt=101 110",
               d_cnt, d_gsr, d_gts, d_ready);
    end else n_pass++;
    for (int c = 102; c <= 120; c++) begin
      tick();
      n_total++;
      if ({d_cnt, d_gsr, d_gts, d_ready} !== {32'(c), (c < 111), (c < 115), (c >= 115)}) begin
        $display("FAIL swreq_c%0d: got cnt=%0d gsr=%b gts=%b ready=%b, want %b%b%b",
                 c, d_cnt, d_gsr, d_gts, d_ready, (c < 111), (c < 115), (c >= 115));
      end else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run(input int at, input logic exp_done);
    $display("test_reset_mid_run: reset at cycle_count=%0d", at);
    run_to(at);
    n_total++;
    if (d_done !== exp_done) begin
      $display("FAIL midrun_done_before_%0d: got done=%b, want %b", at, d_done, exp_done);
    end else n_pass++;
    reset = 1'b1;
    tick();
    n_total++;
    if ({d_cnt, d_gsr, d_gts, d_ready, d_done} !== {32'd0, 4'b1100}) begin
      $display("FAIL midrun_reset_%0d: got cnt=%0d gsr=%b gts=%b ready=%b done=%b, want cnt=0 1100",
               at, d_cnt, d_gsr, d_gts, d_ready, d_done);
    end else n_pass++;
  endtask

  task automatic test_run_limit();
    $display("test_run_limit: done at cycle_count=1150");
    run_to(1149);
    n_total++;
    if ({d_cnt, d_done, d_ready} !== {32'd1149, 2'b01}) begin
      $display("FAIL limit_1149: got cnt=%0d done=%b ready=%b, want cnt=1149 done=0 ready=1",
               d_cnt, d_done, d_ready);
    end else n_pass++;
    for (int c = 1150; c <= 1200; c++) begin
      tick();
      n_total++;
      if ({d_cnt, d_done} !== {32'(c), 1'b1}) begin
        $display("FAIL limit_c%0d: got cnt=%0d done=%b, want cnt=%0d done=1", c, d_cnt, d_done, c);
      end else n_pass++;
    end
  endtask

  task automatic test_param_corners();
    $display("test_param_corners: 2000 cycles from reset");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      tick();
      n_total++;
      if ({g_gsr, g_gts, g_ready} !== {(n < 10), (n < 10), (n >= 10)}) begin
        $display("FAIL gts0_n%0d: got gsr=%b gts=%b ready=%b, want %b%b%b",
                 n, g_gsr, g_gts, g_ready, (n < 10), (n < 10), (n >= 10));
      end else n_pass++;
      n_total++;
      if (m_done !== 1'b0) begin
        $display("FAIL max0_n%0d: got done=%b, want 0", n, m_done);
      end else n_pass++;
      n_total++;
      if ({w_cnt, w_done} !== {8'(n), (n >= 200)}) begin
        $display("FAIL w8_n%0d: got cnt=%0d done=%b, want cnt=%0d done=%b",
                 n, w_cnt, w_done, n % 256, (n >= 200));
      end else n_pass++;
      n_total++;
      if (d_done !== (n >= 1150)) begin
        $display("FAIL dflt_done_n%0d: got done=%b, want %b", n, d_done, (n >= 1150));
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sequence(0);
    test_sw_resequence();
    test_reset_mid_run(500, 1'b0);
    test_sequence(5);
    test_run_limit();
    test_reset_mid_run(1200, 1'b1);
    test_sequence(0);
    test_param_corners();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/glbl_ctrl.md
Name: glbl_ctrl

Overview:
Global control sequencer for the riscv32i core subsystem. After reset it drives the global set/reset (gsr) and global tristate (gts) strobes through a fixed release sequence, then asserts ready. It also keeps a free-running cycle counter and a sticky run-limit flag, which the core and simulation control use to bound execution. It has one clock domain and no combinational paths from inputs to outputs.

Parameters:
CNT_W, 32, width of cycle_count.
GSR_CYCLES, 10, cycles gsr stays high after reset release; legal range is 1 or more.
GTS_CYCLES, 4, cycles gts stays high after gsr drops; 0 skips the GTS phase.
MAX_CYCLES, 1150, cycle_count value at which done asserts; 0 disables done.

Ports:
clk  input  1  system clock, rising-edge only.
reset  input  1  synchronous, active-high reset.
sw_rst_req  input  1  single-cycle request to re-run the gsr/gts sequence; honoured only in RUN.
gsr  output  1  global set/reset strobe, active high.
gts  output  1  global tristate strobe, active high.
ready  output  1  high when the sequence is complete and the system is running.
done  output  1  sticky run-limit flag.
cycle_count  output  CNT_W  cycles since the last reset release.

Behaviour:
- Reset is synchronous and active-high. Every rising clk edge with reset=1 loads: state=GSR, phase counter=0, gsr=1, gts=1, ready=0, done=0, cycle_count=0.
- Reset asserted mid-sequence or mid-run aborts immediately to the reset values. There is no other clear path.
- All outputs are registered.
- cycle_count increments by 1 on every edge with reset=0, in every state.
  - It wraps from 2^CNT_W-1 to 0.
  - The first edge after reset release makes cycle_count=1.
- States: GSR -> GTS -> RUN.
  - Each state keeps a phase counter that is cleared on entry and incremented every cycle.
- GSR state: gsr=1, gts=1, ready=0.
  - Leave after GSR_CYCLES edges in the state.
  - Go to GTS if GTS_CYCLES>0, otherwise to RUN.
  - gsr drops on the edge that leaves GSR.
- GTS state: gsr=0, gts=1, ready=0.
  - Go to RUN after GTS_CYCLES edges; gts drops and ready rises on that edge.
- RUN state: gsr=0, gts=0, ready=1.
  - sw_rst_req=1 sampled in RUN: on the next edge go to GSR, with gsr=1, gts=1, ready=0 and the phase counter cleared.
  - cycle_count and done are not affected by sw_rst_req.
- sw_rst_req in GSR or GTS is ignored and not queued.
- done: set on the edge where cycle_count becomes MAX_CYCLES (MAX_CYCLES≠0).
  - It stays set until reset; wrap-around of cycle_count does not clear it.
  - done is independent of state; it may set before RUN if MAX_CYCLES is small.
- Simultaneous reset and sw_rst_req: reset wins.
- Defaults give these edges after reset release:
  - gsr falls when cycle_count becomes 10.
  - ready rises when cycle_count becomes 14.
  - done rises when cycle_count becomes 1150.

Test Plan:
- Power-on: hold reset for 3 cycles -> gsr=1, gts=1, ready=0, done=0, cycle_count=0 throughout. Release reset -> cycle_count reads 1,2,3… on successive edges; gsr falls with cycle_count=10; gts falls and ready rises with cycle_count=14.
- Run limit: run 1150 cycles after release -> done rises exactly as cycle_count becomes 1150 and stays high through cycle 1200.
- Software re-sequence: pulse sw_rst_req at cycle_count=100 in RUN.
  - Next edge: gsr=1, gts=1, ready=0.
  - gsr falls 10 edges later, ready returns 4 edges after that.
  - cycle_count continues uninterrupted.
- Ignored request: pulse sw_rst_req at cycle_count=5 (GSR phase) -> no extension; ready still rises at cycle_count=14.
- Reset mid-run: assert reset at cycle_count=500 with done=0, then at cycle_count=1200 with done=1.
  - Each time, the next edge gives cycle_count=0, done=0, gsr=1, gts=1, ready=0.
  - After release the full sequence repeats with identical timing.
- Parameter corners:
  - GTS_CYCLES=0 -> gsr falls and ready rises on the same edge (cycle_count=10); gts falls on that same edge.
  - MAX_CYCLES=0 -> done never asserts over 2000 cycles.
  - CNT_W=8 -> cycle_count wraps 255->0 and done stays set.
